// File: rtl/xg_mem_pkg.sv
// Shared state type and geometry constants for the XG burst memory responder.
package xg_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_RESP
    } xg_resp_state_t;

    localparam int XG_BURST_LEN = 4;
    localparam int XG_ADDR_W    = 24;
    localparam int XG_DATA_W    = 16;

endpackage

// File: rtl/xg_mem_responder.sv
// Memory-side end of the XG burst interface: expands each mem_req into a 4-word
// aligned burst of single-word backend accesses, with a one-deep pending request slot.
module xg_mem_responder
    import xg_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = XG_ADDR_W,
    parameter int DATA_WIDTH = XG_DATA_W
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_wren,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] to_mem,
    output logic                  mem_ready,
    output logic [1:0]            mem_offset,
    output logic [DATA_WIDTH-1:0] from_mem,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  be_req,
    output logic                  be_wren,
    output logic [ADDR_WIDTH-1:0] be_addr,
    output logic [DATA_WIDTH-1:0] be_wdata,
    input  logic                  be_ack,
    input  logic [DATA_WIDTH-1:0] be_rdata
);

    localparam logic [1:0]            LAST_BEAT = 2'(XG_BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(XG_BURST_LEN - 1);

    xg_resp_state_t        state, state_next;
    logic [1:0]            beat, beat_next;
    logic [ADDR_WIDTH-1:0] base, base_next;
    logic                  wren, wren_next;
    logic                  slot_full, slot_full_next;
    logic [ADDR_WIDTH-1:0] slot_addr, slot_addr_next;
    logic                  slot_wren, slot_wren_next;
    logic                  err_next;
    logic                  last_resp;

    assign last_resp = (state == S_RESP) && (beat == LAST_BEAT);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        beat_next      = beat;
        base_next      = base;
        wren_next      = wren;
        slot_full_next = slot_full;
        slot_addr_next = slot_addr;
        slot_wren_next = slot_wren;
        err_next       = err_overrun;

        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    base_next  = mem_addr & ~BEAT_MASK;
                    wren_next  = mem_wren;
                    beat_next  = '0;
                    state_next = S_BEAT;
                end
            end
            S_BEAT: begin
                if (be_ack) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (beat != LAST_BEAT) begin
                    beat_next  = beat + 2'd1;
                    state_next = S_BEAT;
                end else if (slot_full) begin
                    base_next      = slot_addr;
                    wren_next      = slot_wren;
                    beat_next      = '0;
                    slot_full_next = 1'b0;
                    state_next     = S_BEAT;
                end else if (mem_req) begin
                    base_next  = mem_addr & ~BEAT_MASK;
                    wren_next  = mem_wren;
                    beat_next  = '0;
                    state_next = S_BEAT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // In the last response cycle a full slot drains into the next burst, so a
        // simultaneous request refills it; with an empty slot it was taken directly above.
        if (mem_req && state != S_IDLE) begin
            if (slot_full && !last_resp) begin
                err_next = 1'b1;
            end else if (slot_full || !last_resp) begin
                slot_full_next = 1'b1;
                slot_addr_next = mem_addr & ~BEAT_MASK;
                slot_wren_next = mem_wren;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            beat        <= '0;
            base        <= '0;
            wren        <= 1'b0;
            slot_full   <= 1'b0;
            slot_addr   <= '0;
            slot_wren   <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
            be_req      <= 1'b0;
            be_wren     <= 1'b0;
            be_addr     <= '0;
            be_wdata    <= '0;
            mem_ready   <= 1'b0;
            mem_offset  <= '0;
            from_mem    <= '0;
        end else begin
            beat        <= beat_next;
            base        <= base_next;
            wren        <= wren_next;
            slot_full   <= slot_full_next;
            slot_addr   <= slot_addr_next;
            slot_wren   <= slot_wren_next;
            err_overrun <= err_next;
            busy        <= (state_next != S_IDLE) | slot_full_next;
            be_req      <= (state_next == S_BEAT);
            be_wren     <= wren_next;
            be_addr     <= base_next | ADDR_WIDTH'(beat_next);
            mem_ready   <= (state_next == S_RESP);
            if (state_next == S_BEAT && state != S_BEAT) begin
                be_wdata <= to_mem;
            end
            if (state_next == S_RESP) begin
                mem_offset <= beat;
            end
            if (state == S_BEAT && be_ack && !wren) begin
                from_mem <= be_rdata;
            end
        end
    end

endmodule

// File: tb/tb_xg_mem_responder.sv
// Randomized scoreboard bench for xg_mem_responder with a behavioural backend and master.
module tb_xg_mem_responder;

    typedef struct {
        logic [23:0] addr;
        logic        wr;
        logic [15:0] data;
    } be_t;

    typedef struct {
        logic [1:0]  off;
        logic        wr;
        logic [15:0] data;
    } rsp_t;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_wren;
    logic [23:0] mem_addr;
    logic [15:0] to_mem;
    logic        mem_ready;
    logic [1:0]  mem_offset;
    logic [15:0] from_mem;
    logic        busy;
    logic        err_overrun;
    logic        be_req;
    logic        be_wren;
    logic [23:0] be_addr;
    logic [15:0] be_wdata;
    logic        be_ack;
    logic [15:0] be_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepted;
    int completed;
    int ack_mode;
    logic exp_err;
    be_t  exp_be[$];
    rsp_t exp_rsp[$];
    logic [15:0] wq[$];
    int rdy_cyc[$];

    xg_mem_responder #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .mem_req(mem_req), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .to_mem(to_mem), .mem_ready(mem_ready),
        .mem_offset(mem_offset), .from_mem(from_mem), .busy(busy),
        .err_overrun(err_overrun), .be_req(be_req), .be_wren(be_wren),
        .be_addr(be_addr), .be_wdata(be_wdata), .be_ack(be_ack), .be_rdata(be_rdata)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endfunction

    function automatic logic [15:0] rd_model(input logic [23:0] a);
        return a[15:0] ^ 16'hA120 ^ {a[23:16], 8'h00};
    endfunction

    // Master side: one-cycle request plus reference expectations for the whole burst.
    task automatic issue(input logic [23:0] a, input logic w, input logic [63:0] words);
        logic [23:0] ba;
        logic [15:0] wd;
        mem_req  = 1'b1;
        mem_addr = a;
        mem_wren = w;
        if (accepted - completed >= 2) begin
            exp_err = 1'b1;
        end else begin
            accepted++;
            for (int unsigned k = 0; k < 4; k++) begin
                ba = (a & ~24'h3) + 24'(k);
                wd = words[16*k +: 16];
                exp_be.push_back('{ba, w, w ? wd : 16'h0});
                exp_rsp.push_back('{2'(k), w, w ? 16'h0 : rd_model(ba)});
                if (w) wq.push_back(wd);
            end
        end
        @(negedge clk_sys);
        mem_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(accepted == completed && !busy) && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 1);
    endtask

    task automatic wait_beat(input logic [1:0] b, input int budget);
        int n;
        n = 0;
        while (!(be_req && be_addr[1:0] == b) && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("wait_beat_timeout", 32'(n < budget), 1);
    endtask

    task automatic wait_final_resp(input int budget);
        int n;
        n = 0;
        while (!(mem_ready && mem_offset == 2'd3) && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("wait_final_timeout", 32'(n < budget), 1);
    endtask

    // Write data source: always presents the oldest unconsumed write word.
    initial forever begin
        @(negedge clk_sys);
        #1;
        to_mem = (wq.size() > 0) ? wq[0] : 16'h0;
    end

    // Backend: acks after ack_mode cycles (random 0..3 when negative), checks each access.
    initial begin
        int held;
        int cur_delay;
        logic [23:0] a0;
        logic        w0;
        logic [15:0] d0;
        be_t e;
        held = 0;
        cur_delay = 0;
        a0 = '0;
        w0 = 1'b0;
        d0 = '0;
        be_ack = 1'b0;
        be_rdata = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!rst_n) begin
                held = 0;
                be_ack = 1'b0;
            end else if (be_req) begin
                if (held == 0) begin
                    cur_delay = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
                    a0 = be_addr;
                    w0 = be_wren;
                    d0 = be_wdata;
                end else begin
                    check("be_addr_stable", be_addr, a0);
                    check("be_wren_stable", be_wren, w0);
                    check("be_wdata_stable", be_wdata, d0);
                end
                if (held == cur_delay) begin
                    be_ack = 1'b1;
                    be_rdata = rd_model(be_addr);
                    if (exp_be.size() == 0) begin
                        fail("unexpected_be_access");
                    end else begin
                        e = exp_be.pop_front();
                        check("be_addr", be_addr, e.addr);
                        check("be_wren", be_wren, e.wr);
                        if (e.wr) check("be_wdata", be_wdata, e.data);
                    end
                end else begin
                    be_ack = 1'b0;
                end
                held++;
            end else begin
                if (held > 0) check("be_req_cycles", held, cur_delay + 1);
                held = 0;
                be_ack = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pop on every mem_ready plus per-cycle status checks.
    initial begin
        logic prev_rdy;
        rsp_t r;
        completed = 0;
        prev_rdy = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!rst_n) begin
                prev_rdy = 1'b0;
            end else begin
                if (prev_rdy) check("be_req_after_ready", be_req, 32'(accepted > completed));
                check("busy", busy, 32'(accepted > completed));
                check("err_overrun", err_overrun, exp_err);
                prev_rdy = mem_ready;
                if (mem_ready) begin
                    rdy_cyc.push_back(cyc);
                    if (exp_rsp.size() == 0) begin
                        fail("unexpected_mem_ready");
                    end else begin
                        r = exp_rsp.pop_front();
                        check("mem_offset", mem_offset, r.off);
                        if (!r.wr) check("from_mem", from_mem, r.data);
                        else if (wq.size() > 0) void'(wq.pop_front());
                        if (r.off == 2'd3) completed++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        mem_req = 1'b0;
        mem_wren = 1'b0;
        mem_addr = '0;
        ack_mode = 0;
        exp_err = 1'b0;
        accepted = 0;
        repeat (3) @(negedge clk_sys);
        check("rst_be_req", be_req, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_overrun, 0);
        check("rst_be_addr", be_addr, 0);
        check("rst_from_mem", from_mem, 0);
        check("rst_offset", mem_offset, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // Read burst, immediate ack: fixed latency T+2,4,6,8.
        rdy_cyc.delete();
        t0 = cyc;
        issue(24'h000120, 1'b0, 64'h0);
        drain(200);
        check("t1_ready_count", rdy_cyc.size(), 4);
        for (int i = 0; i < 4 && i < rdy_cyc.size(); i++)
            check("t1_ready_cycle", rdy_cyc[i], t0 + 2 + 2 * i);

        // Write burst, unaligned base.
        @(negedge clk_sys);
        rdy_cyc.delete();
        issue(24'h010007, 1'b1, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        drain(200);
        check("t2_ready_count", rdy_cyc.size(), 4);
        check("t2_from_mem_hold", from_mem, 16'hA003);

        // Slow backend.
        ack_mode = 3;
        @(negedge clk_sys);
        rdy_cyc.delete();
        issue(24'h3A5C41, 1'b0, 64'h0);
        drain(400);
        check("t3_ready_count", rdy_cyc.size(), 4);

        // Request in the final response cycle with an empty slot.
        ack_mode = 0;
        @(negedge clk_sys);
        issue(24'h00F00C, 1'b0, 64'h0);
        wait_final_resp(100);
        issue(24'h00F012, 1'b1, {16'hD004, 16'hC003, 16'hB002, 16'hA001});
        drain(200);
        check("t6_err_clear", err_overrun, 0);

        // Queued second request, dropped third.
        @(negedge clk_sys);
        issue(24'h200400, 1'b0, 64'h0);
        wait_beat(2'd1, 100);
        issue(24'h200800, 1'b0, 64'h0);
        issue(24'h200C00, 1'b1, 64'h1234_5678_9ABC_DEF0);
        drain(400);
        check("t4_err_set", err_overrun, 1);

        // Random traffic with random ack delays.
        ack_mode = -1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_sys);
            issue(24'($urandom), 1'($urandom), {$urandom, $urandom});
        end
        drain(3000);

        // Asynchronous reset in beat 2.
        ack_mode = 3;
        @(negedge clk_sys);
        issue(24'h0055A2, 1'b1, {$urandom, $urandom});
        wait_beat(2'd2, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_be_req", be_req, 0);
        check("t5_async_mem_ready", mem_ready, 0);
        exp_rsp.delete();
        exp_be.delete();
        wq.delete();
        accepted = completed;
        exp_err = 1'b0;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        check("t5_busy", busy, 0);
        check("t5_err", err_overrun, 0);
        ack_mode = 0;
        rdy_cyc.delete();
        issue(24'h000ABC, 1'b0, 64'h0);
        drain(200);
        check("t5_ready_count", rdy_cyc.size(), 4);

        repeat (3) @(negedge clk_sys);
        check("end_rsp_queue", exp_rsp.size(), 0);
        check("end_be_queue", exp_be.size(), 0);
        check("end_wq", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
